// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port-A arbiter: lock FSM encoding,
// read pipeline depth and owner-id width helper.
package ram_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Grant to read data: one cycle for the command register, one for the RAM.
  localparam int RD_LAT = 2;

  // Burst counter width; MAX_BURST tops out at 15.
  localparam int CNT_W = 4;

  // Owner-id width, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_ID_W    = id_width(DEFAULT_NUM_REQ);

endpackage

// File: rtl/rr_arbiter.sv
// Pure round-robin pick: first requester at or after ptr (wrapping) wins.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        gnt[(int'(ptr) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port A between NUM_REQ requesters: round-robin with burst locking,
// registered RAM command and read-data routing back to the issuing requester.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      ram_write_enable,
  output logic                      ram_output_enable,
  output logic [ADDR_W-1:0]         ram_address,
  output logic [DATA_W-1:0]         ram_data_in,
  input  logic [DATA_W-1:0]         ram_data_out,
  output logic                      busy
);

  localparam int ID_W = id_width(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  arb_state_t       state_reg, state_next;
  logic [ID_W-1:0]  ptr_reg, ptr_next;
  logic [ID_W-1:0]  owner_reg, owner_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [NUM_REQ-1:0] rr_gnt;
  logic [NUM_REQ-1:0] gnt_int;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [ID_W-1:0]    win_id;
  logic [CNT_W-1:0]   beat_cnt;
  logic               competitor;
  logic               owner_waiting_rivals;

  rr_arbiter #(
    .N    (NUM_REQ),
    .PTR_W(ID_W)
  ) u_rr (
    .req(req),
    .ptr(ptr_reg),
    .gnt(rr_gnt)
  );

  assign owner_onehot = NUM_REQ'(1) << owner_reg;

  always_comb begin
    state_next           = state_reg;
    ptr_next             = ptr_reg;
    owner_next           = owner_reg;
    count_next           = count_reg;
    gnt_int              = '0;
    win_id               = '0;
    beat_cnt             = '0;
    competitor           = 1'b0;
    owner_waiting_rivals = 1'b0;

    if (!rst) begin
      case (state_reg)
        ST_IDLE:   gnt_int = rr_gnt;
        ST_LOCKED: gnt_int = req[owner_reg] ? owner_onehot : '0;
        default:   gnt_int = '0;
      endcase
    end

    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_int[k]) win_id = ID_W'(k);
    end

    competitor = |(req & ~gnt_int);
    // Beat number this grant would be within a burst, saturating at MAX_BURST.
    if (state_reg == ST_IDLE) beat_cnt = CNT_W'(1);
    else if (count_reg >= CNT_MAX) beat_cnt = CNT_MAX;
    else beat_cnt = count_reg + 1'b1;

    if (|gnt_int) begin
      ptr_next = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
      if (req_lock[win_id] && !(beat_cnt == CNT_MAX && competitor)) begin
        state_next = ST_LOCKED;
        owner_next = win_id;
        count_next = beat_cnt;
      end else begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    end else if (state_reg == ST_LOCKED) begin
      // An exhausted owner that has gone quiet must not starve others.
      owner_waiting_rivals = (count_reg == CNT_MAX) && |(req & ~owner_onehot);
      if (owner_waiting_rivals) begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      count_reg <= count_next;
    end
  end

  logic              we_reg, oe_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] din_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg   <= 1'b0;
      oe_reg   <= 1'b0;
      addr_reg <= '0;
      din_reg  <= '0;
    end else if (|gnt_int) begin
      we_reg   <= req_we[win_id];
      oe_reg   <= ~req_we[win_id];
      addr_reg <= addr_arr[win_id];
      if (req_we[win_id]) din_reg <= wdata_arr[win_id];
    end else begin
      we_reg <= 1'b0;
      oe_reg <= 1'b0;
    end
  end

  // Owner-id pipeline: stage 0 aligns with the RAM command, the last with data_out.
  logic            rd_vld_reg [RD_LAT];
  logic [ID_W-1:0] rd_id_reg  [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_reg[0] <= 1'b0;
      rd_id_reg[0]  <= '0;
    end else begin
      rd_vld_reg[0] <= (|gnt_int) && !req_we[win_id];
      rd_id_reg[0]  <= win_id;
    end
  end

  generate
    for (gi = 1; gi < RD_LAT; gi++) begin : g_rd_pipe
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_vld_reg[gi] <= 1'b0;
          rd_id_reg[gi]  <= '0;
        end else begin
          rd_vld_reg[gi] <= rd_vld_reg[gi-1];
          rd_id_reg[gi]  <= rd_id_reg[gi-1];
        end
      end
    end
  endgenerate

  assign gnt               = gnt_int;
  assign rd_valid          = rd_vld_reg[RD_LAT-1] ? (NUM_REQ'(1) << rd_id_reg[RD_LAT-1]) : '0;
  assign rd_data           = rd_vld_reg[RD_LAT-1] ? ram_data_out : '0;
  assign ram_write_enable  = we_reg;
  assign ram_output_enable = oe_reg;
  assign ram_address       = addr_reg;
  assign ram_data_in       = din_reg;
  assign busy              = (state_reg == ST_LOCKED);

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port (port A) of dual_port_ram between NUM_REQ requesters using round-robin arbitration with optional burst locking.
- Registers the RAM command, tracks in-flight reads and routes read data back to the originating requester.
- Sits between producer/consumer engines and the RAM. Port B stays free for an independent-clock reader.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- MAX_BURST, 4, max consecutive locked beats before forced rotation (1..15)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester beat request
- req_we  in  NUM_REQ  1 = write beat, 0 = read beat
- req_lock  in  NUM_REQ  hold ownership for the following beat
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot; beat accepted this cycle
- rd_valid  out  NUM_REQ  one-hot; rd_data belongs to this requester
- rd_data  out  DATA_W  read return data
- ram_write_enable  out  1  to write_enable_a
- ram_output_enable  out  1  to output_enable_a
- ram_address  out  ADDR_W  to address_a
- ram_data_in  out  DATA_W  to data_in_a
- ram_data_out  in  DATA_W  from data_out_a
- busy  out  1  a requester currently holds a lock

Behaviour:
- RAM contract: a write commits at the clk edge where write_enable_a=1. A read with output_enable_a=1 presents data on data_out_a after the next edge (1-cycle latency).
- Reset values: gnt=0, rd_valid=0, rd_data=0, ram_write_enable=0, ram_output_enable=0, ram_address=0, ram_data_in=0, busy=0. RR pointer=0, FSM=IDLE, burst count=0.
- gnt is combinational from req and state. A requester keeps req and its fields stable until it sees gnt, then may change them on the next cycle.
- Beat granted in cycle t:
  - t+1: ram_* carries the registered command.
  - Write beat: RAM commits at the end of t+1.
  - Read beat: rd_valid[i]=1 and rd_data=ram_data_out in cycle t+2.
- Throughput: one beat per cycle, back-to-back. The read pipeline tracks two stages of owner id.
- Idle cycle (no grant): ram_write_enable=0 and ram_output_enable=0; address and data hold their last values.
- FSM states:
  - IDLE: RR search starts at pointer p. Grant the lowest index ≥ p (wrapping) with req=1. Then p ← winner+1 mod NUM_REQ.
  - IDLE → LOCKED: the granted beat had req_lock=1. Store owner, burst count=1, busy=1.
  - LOCKED: only the owner can be granted; other requesters get no grant.
    - Owner beat with req_lock=1: count+1.
    - Owner beat with req_lock=0: last beat; go to IDLE.
    - Owner req=0: stay LOCKED, no grant.
  - Forced release: count reaches MAX_BURST and any other req=1 → IDLE, lock ignored for that beat. With no competitor the lock persists and the count saturates at MAX_BURST.
- Write immediately followed by a read of the same address returns the new data; the RAM ordering guarantees this and the arbiter adds no bypass.
- req_we ignored when req=0. No requests: gnt=0, FSM unchanged.
- rst mid-operation: in-flight reads are dropped (no rd_valid), the lock is cleared, and the pending RAM command is squashed (enables 0 at the next cycle).

Decomposition:
- Shared package ram_arb_pkg: FSM state encoding (IDLE, LOCKED), owner-id width constant $clog2(NUM_REQ), read-latency constant RD_LAT=2.
- One sub-module rr_arbiter: pure round-robin pick (req vector and pointer in, one-hot grant out). The lock FSM, RAM command register and read pipeline stay in the top.

Test Plan:
- Reset, then req=4'b0001 write addr 40 data A0 → gnt[0] at t, ram_write_enable=1, ram_address=40, ram_data_in=A0 at t+1.
- Req0 writes 40..44 data A0..A4, then req2 reads 40..44 back-to-back → rd_valid[2] pulses five consecutive cycles, rd_data A0..A4, first at gnt+2.
- req=4'b1111 held, no locks → grant order 0,1,2,3,0,1, one beat per cycle.
- Req1 with req_lock=1 while req3 requests, MAX_BURST=4 → 4 grants to 1, then gnt[3]. busy=1 through the burst.
- Req1 locks alone for 10 beats → all 10 granted to 1, busy stays 1, count saturates at 4.
- Read granted at t, rst=1 at t+1 → no rd_valid at t+2, all outputs at reset values, FSM IDLE, pointer 0.
